// File: rtl/note_sequencer_if.sv
// Purpose: host/switch-side bundle for the note sequencer (control, table writes, player status).
// Latency: wires only, no storage.
// Backpressure: none; the sequencer silently drops start/wr_en it cannot accept.
interface note_sequencer_if #(
  parameter int AW = 4
);
  logic          start;
  logic          stop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [4:0]    wr_data;
  logic [7:0]    note_sel;
  logic          tone_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  // host / switch logic side
  modport master (
    output start, stop, wr_en, wr_addr, wr_data,
    input  note_sel, tone_en, busy, done, cur_idx
  );

  // sequencer side
  modport slave (
    input  start, stop, wr_en, wr_addr, wr_data,
    output note_sel, tone_en, busy, done, cur_idx
  );
endinterface

// File: rtl/note_sequencer.sv
// Purpose: plays a host-written DEPTH-entry note table as one-hot note_sel codes with timed notes and gaps.
// Latency: start at cycle n -> busy at n+1 -> note_sel/tone_en at n+2; note = dur ticks, gap = GAP_TICKS ticks.
// Backpressure: none; start and wr_en are dropped while busy, stop always wins.
// Optional feature: define NOTE_SEQ_LOOP_EN to loop the song until stop instead of ending with done.
module note_sequencer #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 100,
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 5
) (
  input logic               clk,
  input logic               rst_n,
  note_sequencer_if.slave   bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PRESC = CLK_HZ / TICK_HZ;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int GW    = $clog2(GAP_TICKS + 1);

  // Table reset value: dur = 11 marks the end of the song.
  localparam logic [4:0] END_ENTRY = 5'b11000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [6:0]    dcnt_q, dcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [7:0]    note_q, note_d;
  logic          done_q, done_d;

  logic [PW-1:0] presc_q;
  logic          presc_clr;
  logic          tick;
  logic          busy;

  logic [4:0]    tbl [DEPTH];
  logic [4:0]    entry;
  logic [1:0]    ent_dur;
  logic [2:0]    ent_note;
  logic [6:0]    ent_ticks;

  assign busy     = (state_q != S_IDLE);
  assign tick     = busy && (presc_q == PW'(PRESC - 1));

  assign entry    = tbl[idx_q];
  assign ent_dur  = entry[4:3];
  assign ent_note = entry[2:0];

  // Duration code to tick count; code 11 never reaches PLAY so its value is irrelevant.
  always_comb begin
    ent_ticks = 7'd100;
    case (ent_dur)
      2'b00:   ent_ticks = 7'd25;
      2'b01:   ent_ticks = 7'd50;
      default: ent_ticks = 7'd100;
    endcase
  end

  // Note table: reset to all-END, host writes accepted only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= END_ENTRY;
      end
    end else if (bus.wr_en && (state_q == S_IDLE)) begin
      tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Restart the prescaler whenever PLAY or GAP is entered so every note/gap
  // gets whole ticks, and hold it at zero while idle.
  assign presc_clr = (state_d == S_IDLE) ||
                     ((state_d == S_PLAY) && (state_q != S_PLAY)) ||
                     ((state_d == S_GAP)  && (state_q != S_GAP));

  // Tick prescaler: free-runs 0..PRESC-1 while busy, one-cycle tick at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (presc_clr || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      gcnt_q  <= '0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      gcnt_q  <= gcnt_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: fetch/play/gap walk through the table, stop overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    note_d  = note_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end

      S_FETCH: begin
        if (ent_dur == 2'b11) begin
`ifdef NOTE_SEQ_LOOP_EN
          // An END at entry 0 means an empty song: finish rather than spin.
          if (idx_q != '0) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          dcnt_d  = ent_ticks;
          note_d  = 8'b1 << ent_note;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick) begin
          if (dcnt_q == 7'd1) begin
            note_d  = '0;
            gcnt_d  = GW'(GAP_TICKS);
            state_d = S_GAP;
          end else begin
            dcnt_d = dcnt_q - 7'd1;
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (gcnt_q == GW'(1)) begin
            if (idx_q == AW'(DEPTH - 1)) begin
`ifdef NOTE_SEQ_LOOP_EN
              idx_d   = '0;
              state_d = S_FETCH;
`else
              done_d  = 1'b1;
              state_d = S_IDLE;
`endif
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: silence immediately, rewind, and suppress any done pulse.
    if (busy && bus.stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      dcnt_d  = '0;
      gcnt_d  = '0;
      note_d  = '0;
      done_d  = 1'b0;
    end
  end

  assign bus.note_sel = note_q;
  assign bus.tone_en  = |note_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.cur_idx  = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Purpose: randomized and directed checking of note_sequencer against a timeline model of the song.
// Latency: model predicts every output of every cycle from the note table and the start/stop/write history.
// Backpressure: model drops start/wr_en whenever it expects the player to be busy.
module tb_note_sequencer;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DEPTH     = 4;
  localparam int GAP_TICKS = 1;
  localparam int AW        = 2;
  localparam int P         = CLK_HZ / TICK_HZ;
`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  note_sequencer_if #(.AW(AW)) bus ();

  note_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .DEPTH    (DEPTH),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic [7:0]    note;
    logic          tone;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t          q[$];
  logic [4:0]    mtbl [DEPTH];
  bit            gen_active;
  int            gen_idx;
  logic [AW-1:0] idle_idx;
  int            total = 0;
  int            bad   = 0;
  int            hist [8];
  int            done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_ticks(input logic [1:0] d);
    if (d == 2'b00) return 25;
    if (d == 2'b01) return 50;
    return 100;
  endfunction

  task automatic push_n(input exp_t e, input int n);
    repeat (n) q.push_back(e);
  endtask

  // Expand the song one table entry at a time into per-cycle expectations:
  // 1 fetch cycle, dur*P tone cycles, GAP_TICKS*P silent cycles, then next entry.
  task automatic extend();
    exp_t       e;
    logic [4:0] ent;
    while (q.size() == 0 && gen_active) begin
      ent    = mtbl[gen_idx];
      e      = '0;
      e.busy = 1'b1;
      e.idx  = gen_idx[AW-1:0];
      q.push_back(e);
      if (ent[4:3] == 2'b11) begin
        if (LOOP && gen_idx != 0) begin
          gen_idx = 0;
        end else begin
          e.busy = 1'b0;
          e.done = 1'b1;
          q.push_back(e);
          gen_active = 1'b0;
        end
      end else begin
        e.note = 8'd1 << ent[2:0];
        e.tone = 1'b1;
        push_n(e, dur_ticks(ent[4:3]) * P);
        e.note = '0;
        e.tone = 1'b0;
        push_n(e, GAP_TICKS * P);
        if (gen_idx == DEPTH - 1) begin
          if (LOOP) begin
            gen_idx = 0;
          end else begin
            e.busy = 1'b0;
            e.done = 1'b1;
            q.push_back(e);
            gen_active = 1'b0;
          end
        end else begin
          gen_idx++;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, then update the model.
  task automatic step(input bit r, input bit s, input bit p, input bit we,
                      input logic [AW-1:0] wa, input logic [4:0] wd);
    exp_t cur;
    if (q.size() == 0) extend();
    if (q.size() != 0) begin
      cur      = q.pop_front();
      idle_idx = cur.idx;
    end else begin
      cur     = '0;
      cur.idx = idle_idx;
    end
    rst_n       = ~r;
    bus.start   = s;
    bus.stop    = p;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    @(negedge clk);
    check("note_sel", 32'(bus.note_sel), 32'(cur.note));
    check("tone_en",  32'(bus.tone_en),  32'(cur.tone));
    check("busy",     32'(bus.busy),     32'(cur.busy));
    check("done",     32'(bus.done),     32'(cur.done));
    check("cur_idx",  32'(bus.cur_idx),  32'(cur.idx));
    check("onehot0",  32'($onehot0(bus.note_sel)), 32'd1);
    check("tone_or",  32'(bus.tone_en),  32'(|bus.note_sel));
    for (int b = 0; b < 8; b++) if (bus.note_sel[b] === 1'b1) hist[b]++;
    if (bus.done === 1'b1) done_cnt++;
    if (r) begin
      q.delete();
      gen_active = 1'b0;
      idle_idx   = '0;
      for (int i = 0; i < DEPTH; i++) mtbl[i] = 5'b11000;
    end else begin
      if (p && cur.busy) begin
        q.delete();
        gen_active = 1'b0;
        idle_idx   = '0;
      end
      if (we && !cur.busy) mtbl[wa] = wd;
      if (s && !p && !cur.busy) begin
        gen_active = 1'b1;
        gen_idx    = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [4:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic go();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic clear_stats();
    for (int b = 0; b < 8; b++) hist[b] = 0;
    done_cnt = 0;
  endtask

  function automatic int tone_sum();
    int s = 0;
    for (int b = 0; b < 8; b++) s += hist[b];
    return s;
  endfunction

  // Run until the model says the song is over; an overrun counts as a failure.
  task automatic run_done(input string tag, input int max_cycles);
    int n = 0;
    while ((q.size() != 0 || gen_active) && n < max_cycles) begin
      idle(1);
      n++;
    end
    check(tag, 32'(q.size() != 0 || gen_active), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    gen_active  = 1'b0;
    gen_idx     = 0;
    idle_idx    = '0;
    for (int i = 0; i < DEPTH; i++) mtbl[i] = 5'b11000;
    clear_stats();
    @(posedge clk);
    #1;

    // Reset state, then an empty table: done two cycles after start, no tone.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(2);
    clear_stats();
    go();
    run_done("s1_bound", 20);
    check("s1_done_cnt", 32'(done_cnt), 32'd1);
    check("s1_no_tone", 32'(tone_sum()), 32'd0);

    // Two notes then END: C4 for 250 clk, G4 for 500 clk.
    wr(2'd0, 5'b00000);
    wr(2'd1, 5'b01100);
    wr(2'd2, 5'b11000);
    clear_stats();
    go();
    run_done("s2_bound", 2000);
    check("s2_c4_len", 32'(hist[0]), 32'd250);
    check("s2_g4_len", 32'(hist[4]), 32'd500);
    check("s2_done_cnt", 32'(done_cnt), 32'd1);

    // Full table of short notes: ends after the gap of the last entry.
    wr(2'd0, 5'b00001);
    wr(2'd1, 5'b00011);
    wr(2'd2, 5'b00101);
    wr(2'd3, 5'b00110);
    clear_stats();
    go();
    run_done("s3_bound", 3000);
    check("s3_tone_total", 32'(tone_sum()), 32'd1000);
    check("s3_done_cnt", 32'(done_cnt), 32'd1);

    // Stop 100 clk into the first note, then replay from entry 0.
    wr(2'd0, 5'b01010);
    clear_stats();
    go();
    idle(101);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    idle(20);
    check("s4_stopped_len", 32'(hist[2]), 32'd101);
    check("s4_no_done", 32'(done_cnt), 32'd0);
    clear_stats();
    go();
    run_done("s4_bound", 3000);
    check("s4_replay_len", 32'(hist[2]), 32'd500);
    check("s4_replay_done", 32'(done_cnt), 32'd1);

    // start and stop together while idle: nothing happens.
    clear_stats();
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    idle(5);
    check("s5_no_done", 32'(done_cnt), 32'd0);

    // A write during PLAY is dropped; the replay must still use the old entry 1.
    clear_stats();
    go();
    idle(30);
    wr(2'd1, 5'b10111);
    run_done("s6_bound", 3000);
    check("s6_b4_absent", 32'(hist[7]), 32'd0);
    check("s6_tone_total", 32'(tone_sum()), 32'd1250);

    // Reset mid-song restores the all-END table.
    go();
    idle(40);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(3);
    clear_stats();
    go();
    run_done("s7_bound", 20);
    check("s7_done_cnt", 32'(done_cnt), 32'd1);
    check("s7_no_tone", 32'(tone_sum()), 32'd0);

`ifdef NOTE_SEQ_LOOP_EN
    // Loop mode: one note then END repeats until stop, never pulsing done.
    wr(2'd0, 5'b00001);
    wr(2'd1, 5'b11000);
    clear_stats();
    go();
    idle(1000);
    check("s8_no_done", 32'(done_cnt), 32'd0);
    check("s8_repeats", 32'(hist[1] > 700), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    idle(10);
`endif

    // Random traffic: writes, starts, rare stops and resets.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 25000; i++) begin
      step(($urandom % 6000) == 0,
           ($urandom % 25) == 0,
           ($urandom % 1200) == 0,
           ($urandom % 4) == 0,
           AW'($urandom),
           5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
